// File: rtl/data_memory_16384x32.sv
// -----------------------------------------------------------------------------
// data_memory_16384x32
//
// 16384 x 32-bit word-addressed data memory for the MEM stage of the MIPS
// datapath. Writes land on the rising edge of clk; reads are combinational.
// A per-word valid vector is cleared asynchronously by rst_n, so any word not
// written since the last reset reads back as zero. The data array itself is
// never cleared.
//
// Optional feature macro: DMEM_ADDR_CHECK_EN
//   undefined (default): addr[31:16] is ignored, upper addresses alias onto
//                        the low 64 KiB.
//   defined:             any access with addr[31:16] != 0 is out of range;
//                        such writes are dropped and such reads return zero.
// -----------------------------------------------------------------------------
module data_memory_16384x32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] readData
);

    localparam int unsigned DEPTH  = 16384;
    localparam int unsigned IDX_W  = 14;
    localparam int unsigned DATA_W = 32;

    // Storage: data array (no reset) and one valid bit per word (async clear).
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;

    // Decoded access controls.
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic              wr_en_s;
    logic              rd_hit_s;

    // Address bits that never select a word; byte offset is always dropped and
    // the upper half is only consulted by the range check when it is enabled.
    logic              unused_addr_s;
    assign unused_addr_s = ^{addr[31:16], addr[1:0]};

    // Word index and range qualification for the current address.
    always_comb begin
        idx_s      = addr[15:2];
`ifdef DMEM_ADDR_CHECK_EN
        if (addr[31:16] == 16'h0000) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = 1'b0;
        end
`else
        in_range_s = 1'b1;
`endif
    end

    // Write qualification: reset low blocks writes, so a write pending when
    // rst_n drops mid-cycle is aborted at the edge.
    always_comb begin
        wr_en_s = 1'b0;
        if (rst_n && MemWrite && in_range_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state of the valid vector: a qualified write marks its word valid.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_s) begin
            valid_d[idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid vector register; rst_n falling invalidates every word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {DEPTH{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data array write port; contents deliberately survive reset because the
    // valid vector already masks stale words.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[idx_s] <= writeData;
        end
    end

    // Read hit: word must be enabled, in range, valid and out of reset.
    always_comb begin
        rd_hit_s = 1'b0;
        if (rst_n && MemRead && in_range_s && valid_q[idx_s]) begin
            rd_hit_s = 1'b1;
        end else begin
            rd_hit_s = 1'b0;
        end
    end

    // Combinational read data; a write on this edge becomes visible right
    // after the edge because the path reads the array and valid bits directly.
    always_comb begin
        readData = 32'h0000_0000;
        if (rd_hit_s) begin
            readData = mem_q[idx_s];
        end else begin
            readData = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_memory_16384x32.sv
// -----------------------------------------------------------------------------
// tb_data_memory_16384x32
//
// Self-checking bench for data_memory_16384x32. Each read stimulus pushes its
// expected readData (and a tag) into a scoreboard queue; the sampled DUT
// output is popped and compared one time unit later. Inputs change on the
// falling clock edge so they are stable around the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_memory_16384x32;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] readData;

    int unsigned chk_cnt;
    int unsigned err_cnt;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    data_memory_16384x32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .writeData(writeData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .readData (readData)
    );

    // Free-running clock, 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Push expected readData for the stimulus currently on the pins.
    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Pop the oldest expectation and compare against the DUT output.
    task automatic sb_pop_check();
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, readData, e);
        end
    endtask

    // One full-cycle write: drive at negedge, commit at the next posedge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr      = a;
        writeData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    // Combinational read at negedge, sampled 1 ns later.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr     = a;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        sb_push(tag, exp);
        #1;
        sb_pop_check();
    endtask

    logic [31:0] alias_exp_lo;
    logic [31:0] alias_exp_hi;

    initial begin
        chk_cnt   = 0;
        err_cnt   = 0;
        rst_n     = 1'b0;
        addr      = 32'h0000_0000;
        writeData = 32'h0000_0000;
        MemWrite  = 1'b0;
        MemRead   = 1'b1;

`ifdef DMEM_ADDR_CHECK_EN
        alias_exp_lo = 32'h0000_0001;
        alias_exp_hi = 32'h0000_0000;
`else
        alias_exp_lo = 32'h0000_dead;
        alias_exp_hi = 32'h0000_dead;
`endif

        // Reset state: output zero while rst_n is low, even with MemRead=1.
        #2;
        sb_push("reset_out", 32'h0000_0000);
        #1;
        sb_pop_check();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Unwritten top word reads zero after reset.
        do_read("unwritten_fffc", 32'h0000_fffc, 32'h0000_0000);

        // Basic write sequence then read back.
        do_write(32'h0000_0000, 32'h0000_0001);
        do_write(32'h0000_0004, 32'h0000_0abc);
        do_write(32'h0000_0008, 32'h0000_0112);
        do_write(32'h0000_c008, 32'h0000_0cba);
        do_read("rd_0", 32'h0000_0000, 32'h0000_0001);
        do_read("rd_4", 32'h0000_0004, 32'h0000_0abc);
        do_read("rd_8", 32'h0000_0008, 32'h0000_0112);
        do_read("rd_c008", 32'h0000_c008, 32'h0000_0cba);

        // MemRead gating, then raising MemRead in the same cycle.
        @(negedge clk);
        addr    = 32'h0000_0004;
        MemRead = 1'b0;
        sb_push("rd_gated", 32'h0000_0000);
        #1;
        sb_pop_check();
        MemRead = 1'b1;
        sb_push("rd_ungated", 32'h0000_0abc);
        #1;
        sb_pop_check();

        // Simultaneous read/write: old data before the edge, new after.
        @(negedge clk);
        addr      = 32'h0000_0008;
        writeData = 32'h0000_0055;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        sb_push("rw_before", 32'h0000_0112);
        #1;
        sb_pop_check();
        @(posedge clk);
        #1;
        sb_push("rw_after", 32'h0000_0055);
        #1;
        sb_pop_check();
        MemWrite = 1'b0;

        // Reset mid-cycle: readData drops at once; pending write aborted.
        do_read("pre_reset_4", 32'h0000_0004, 32'h0000_0abc);
        #1;
        rst_n = 1'b0;
        #1;
        sb_push("reset_drop", 32'h0000_0000);
        #1;
        sb_pop_check();
        @(negedge clk);
        addr      = 32'h0000_000c;
        writeData = 32'h0000_0077;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        // Write issued with rst_n high, then reset lands before the edge.
        @(negedge clk);
        rst_n     = 1'b1;
        addr      = 32'h0000_0010;
        writeData = 32'h0000_0099;
        MemWrite  = 1'b1;
        #2;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_read("post_reset_4", 32'h0000_0004, 32'h0000_0000);
        do_read("post_reset_8", 32'h0000_0008, 32'h0000_0000);
        do_read("blocked_wr_c", 32'h0000_000c, 32'h0000_0000);
        do_read("aborted_wr_10", 32'h0000_0010, 32'h0000_0000);

        // Misaligned accesses round down to the word.
        do_write(32'h0000_0006, 32'h0000_1234);
        do_read("misalign_4", 32'h0000_0004, 32'h0000_1234);
        do_read("misalign_7", 32'h0000_0007, 32'h0000_1234);

        // Upper address bits: alias by default, dropped with range check.
        do_write(32'h0000_0000, 32'h0000_0001);
        do_write(32'h0001_0000, 32'h0000_dead);
        do_read("alias_lo", 32'h0000_0000, alias_exp_lo);
        do_read("alias_hi", 32'h0001_0000, alias_exp_hi);

        // Top word, no wrap into word 0.
        do_write(32'h0000_fffc, 32'hffff_ffff);
        do_read("top_fffc", 32'h0000_fffc, 32'hffff_ffff);
        do_read("top_nowrap_0", 32'h0000_0000, alias_exp_lo);

        // Last write to the same word wins.
        do_write(32'h0000_0020, 32'ha5a5_0001);
        do_write(32'h0000_0020, 32'h5a5a_0002);
        do_read("last_wins", 32'h0000_0020, 32'h5a5a_0002);

        check_eq("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/data_memory_16384x32.md
# data_memory_16384x32

Word-addressed 16384 x 32-bit data memory (64 KiB) for the MIPS datapath's MEM stage. Writes are synchronous to the rising clock edge; reads are combinational. An asynchronous active-low reset invalidates every location, so any word not written since reset reads as zero. The ALU result drives `addr`, and `readData` feeds the write-back mux.

## Interface
- Parameters: none. Depth 16384 and width 32 are fixed by the block name.
- `clk` in 1: single clock; all writes happen on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address; the word index is `addr[15:2]`.
- `writeData` in 32: data to store.
- `MemWrite` in 1: write enable, sampled on the rising edge of `clk`.
- `MemRead` in 1: read enable (combinational).
- `readData` out 32: read data. It is 0 while `rst_n`=0 or `MemRead`=0.

## Operation
- Storage:
  - 16384 x 32 data array.
  - 16384-bit valid vector, one bit per word.
- Word index `idx = addr[15:2]`.
  - `addr[1:0]` is ignored; misaligned accesses round down to the word.
  - Without the macro, `addr[31:16]` is ignored and aliases onto the low 64 KiB.
- Write: on a rising edge with `rst_n`=1 and `MemWrite`=1, `mem[idx] <= writeData` and `valid[idx] <= 1`.
- Read: `readData = (rst_n && MemRead && valid[idx]) ? mem[idx] : 32'h0`.
  - The read path is purely combinational from `addr`, `MemRead`, the array and the valid vector.
- `MemRead`=1 together with `MemWrite`=1:
  - The write takes effect at the edge.
  - Before the edge, `readData` shows the old contents.
  - After the edge, `readData` shows the new data (write-then-read across the edge).
- Reset:
  - `rst_n` falling clears all valid bits immediately, without waiting for `clk`.
  - Data array contents are not cleared.
  - Writes are blocked while `rst_n`=0.
  - Reset asserted mid-cycle aborts a pending write; no location changes.
- Writing the same word twice: the last write wins.

## Timing
- Write latency: 1 edge. Data is visible on `readData` combinationally right after the edge.
- Read latency: 0 cycles (combinational).
- No handshake and no stalls; one access per cycle.
- Reset value of `readData`: 32'h0.
- `rst_n` deassertion is synchronized externally. The first write takes effect at the first rising edge with `rst_n`=1.

## Configuration
- Macro `DMEM_ADDR_CHECK_EN`.
- Defined: an access with `addr[31:16] != 0` is out of range.
  - Out-of-range writes are dropped; no array or valid bit changes.
  - Out-of-range reads return 32'h0.
- Undefined: upper address bits are ignored (aliasing). For example, 0x0001_0004 accesses word 1.

## Test plan
- Write sequence, then read back:
  - Writes: 0x0 <- 0x00000001, 0x4 <- 0x00000abc, 0x8 <- 0x00000112, 0xc008 <- 0x00000cba, one per cycle with `MemWrite`=1.
  - Reads with `MemRead`=1, `MemWrite`=0: 0x0 -> 0x1, 0x4 -> 0xabc, 0x8 -> 0x112, 0xc008 (word 0x3002) -> 0xcba.
- `MemRead`=0 at addr 0x4 after the write above -> `readData`=0. Raise `MemRead` -> 0xabc combinationally in the same cycle.
- Simultaneous read/write at 0x8: old 0x112, write 0x55 with `MemRead`=1.
  - Before the edge: 0x112.
  - After the edge: 0x55.
- Reset:
  - Write 0x4 <- 0xabc, then pulse `rst_n`=0 mid-cycle.
  - `readData` drops to 0 immediately.
  - After release, reading 0x4 returns 0.
  - A `MemWrite` issued while `rst_n`=0 leaves the word unwritten; it reads 0.
- Addressing and aliasing:
  - Write 0x6 <- 0x1234, read 0x4 -> 0x1234 (misaligned rounds down).
  - Without `DMEM_ADDR_CHECK_EN`: write 0x0001_0000 <- 0xdead, read 0x0 -> 0xdead.
  - With `DMEM_ADDR_CHECK_EN`: the same write is dropped, and 0x0 keeps its prior value.
- Unwritten word 0xfffc after reset -> 0.
  - Write 0xfffc <- 0xffffffff, read -> 0xffffffff (top word, no wrap).
